// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the 16-bit SPI master
// Contents:
//   spi_state_t          frame sequencer states
//   SPI_FRAME_BITS       bits per frame
//   SPI_DEFAULT_CLK_DIV  default SCK half-period in system clock cycles
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } spi_state_t;

  localparam int SPI_FRAME_BITS      = 16;
  localparam int SPI_DEFAULT_CLK_DIV = 12;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for an asynchronous input
// Ports:
//   clk  in   system clock
//   rst  in   synchronous active-high reset, clears both flops
//   d    in   asynchronous input
//   q    out  synchronized copy of d, two cycles late
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_master16.sv
// rtl/spi_master16.sv - 16-bit SPI mode-0 master with cs_n framing
// Ports:
//   CLK      in   system clock, rising edge
//   RST      in   synchronous active-high reset
//   start    in   frame request, honoured only while idle
//   tx_data  in   frame to send, sampled on acceptance
//   busy     out  frame in progress
//   done     out  one-cycle pulse on return to idle
//   rx_data  out  last frame captured from miso
//   sck      out  SPI clock, idles low
//   mosi     out  serial data out, MSB first
//   cs_n     out  chip select, active low
//   miso     in   serial data in, asynchronous
module spi_master16
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_DEFAULT_CLK_DIV
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [15:0] tx_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] rx_data,
  output logic        sck,
  output logic        mosi,
  output logic        cs_n,
  input  logic        miso
);

  localparam int              DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]      BIT_LAST = 4'(SPI_FRAME_BITS - 1);

  spi_state_t       state, state_n;
  logic [DIV_W-1:0] div_cnt, div_cnt_n;
  logic [3:0]       bit_cnt, bit_cnt_n;
  logic             low_half, low_half_n;
  logic [15:0]      tx_sr, tx_sr_n;
  logic [15:0]      rx_sr;
  logic             miso_s;
  logic             half_end;
  logic             sck_d, mosi_d, cs_n_d, busy_d, done_d;

  sync2 u_miso_sync (
    .clk (CLK),
    .rst (RST),
    .d   (miso),
    .q   (miso_s)
  );

  assign half_end = (div_cnt == DIV_LAST);

  // state register, including the counters and tx shifter that sequence it
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      low_half <= 1'b0;
      tx_sr    <= '0;
    end else begin
      state    <= state_n;
      div_cnt  <= div_cnt_n;
      bit_cnt  <= bit_cnt_n;
      low_half <= low_half_n;
      tx_sr    <= tx_sr_n;
    end
  end

  // next-state logic; every phase lasts CLK_DIV cycles
  always_comb begin
    state_n    = state;
    div_cnt_n  = div_cnt + DIV_W'(1);
    bit_cnt_n  = bit_cnt;
    low_half_n = low_half;
    tx_sr_n    = tx_sr;
    case (state)
      IDLE: begin
        div_cnt_n = '0;
        if (start) begin
          state_n    = SETUP;
          bit_cnt_n  = '0;
          low_half_n = 1'b0;
          tx_sr_n    = tx_data;
        end
      end
      SETUP: begin
        if (half_end) begin
          div_cnt_n  = '0;
          state_n    = SHIFT;
          low_half_n = 1'b0;
        end
      end
      SHIFT: begin
        if (half_end) begin
          div_cnt_n = '0;
          if (!low_half) begin
            // falling sck: present the next bit for the following rise
            low_half_n = 1'b1;
            tx_sr_n    = {tx_sr[14:0], 1'b0};
          end else if (bit_cnt == BIT_LAST) begin
            state_n    = GAP;
            low_half_n = 1'b0;
          end else begin
            bit_cnt_n  = bit_cnt + 4'd1;
            low_half_n = 1'b0;
          end
        end
      end
      GAP: begin
        if (half_end) begin
          div_cnt_n = '0;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // outputs are decoded from the next state so the pins come straight off flops
  always_comb begin
    sck_d  = 1'b0;
    mosi_d = 1'b0;
    cs_n_d = 1'b1;
    busy_d = 1'b1;
    done_d = 1'b0;
    case (state_n)
      IDLE: begin
        busy_d = 1'b0;
        done_d = (state == GAP);
      end
      SETUP: begin
        cs_n_d = 1'b0;
        mosi_d = tx_sr_n[15];
      end
      SHIFT: begin
        cs_n_d = 1'b0;
        sck_d  = !low_half_n;
        // the last low half is chip-select hold time, mosi parked low
        mosi_d = (low_half_n && bit_cnt_n == BIT_LAST) ? 1'b0 : tx_sr_n[15];
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sck     <= 1'b0;
      mosi    <= 1'b0;
      cs_n    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_sr   <= '0;
      rx_data <= '0;
    end else begin
      sck  <= sck_d;
      mosi <= mosi_d;
      cs_n <= cs_n_d;
      busy <= busy_d;
      done <= done_d;
      // sample in the first high-half cycle, a full half-period after the fall
      if (state == SHIFT && !low_half && div_cnt == '0)
        rx_sr <= {rx_sr[14:0], miso_s};
      if (state == GAP && state_n == IDLE)
        rx_data <= rx_sr;
    end
  end

endmodule

// File: tb/tb_spi_master16.sv
// tb/tb_spi_master16.sv - self-checking bench for spi_master16 with a mode-0 slave model
module tb_spi_master16;

  localparam int D = 12;

  logic        CLK;
  logic        RST;
  logic        start;
  logic [15:0] tx_data;
  logic        busy;
  logic        done;
  logic [15:0] rx_data;
  logic        sck;
  logic        mosi;
  logic        cs_n;
  logic        miso;

  spi_master16 #(.CLK_DIV(D)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .start   (start),
    .tx_data (tx_data),
    .busy    (busy),
    .done    (done),
    .rx_data (rx_data),
    .sck     (sck),
    .mosi    (mosi),
    .cs_n    (cs_n),
    .miso    (miso)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // frame model state
  int          acc = -1;
  logic [15:0] acc_tx  = 16'h0;
  logic [15:0] acc_pat = 16'h0;
  logic [15:0] exp_rx  = 16'h0;
  logic [15:0] slave_pat = 16'h0;

  // event logs
  int sck_rises[$];
  int cs_fall[$];
  int cs_rise[$];
  int done_q[$];
  int mosi_hi = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h required 0x%0h", name, cyc, act, req);
    end
  endtask

  // Expected pins at offset t after the accepting edge, from the frame timing rules.
  function automatic void exp_at(input int t, input logic [15:0] tx,
                                 output logic e_cs_n, output logic e_sck,
                                 output logic e_mosi, output logic e_busy,
                                 output logic e_done);
    int u;
    e_busy = (t >= 1) && (t <= 34 * D);
    e_cs_n = !((t >= 1) && (t <= 33 * D));
    e_done = (t == 34 * D + 1);
    u      = t - 1 - D;
    e_sck  = (u >= 0) && (u < 32 * D) && ((u % (2 * D)) < D);
    e_mosi = ((t >= 1) && (t <= 32 * D)) ? tx[15 - (t - 1) / (2 * D)] : 1'b0;
  endfunction

  // model: acceptance and rx_data update, evaluated on the sampling edge
  initial begin
    int   ending;
    logic idle_now;
    forever begin
      @(posedge CLK);
      ending   = cyc;
      idle_now = !(acc >= 0 && ending - acc >= 1 && ending - acc <= 34 * D);
      cyc      = cyc + 1;
      if (RST) begin
        acc    = -1;
        exp_rx = 16'h0;
      end else begin
        if (acc >= 0 && cyc - acc == 34 * D + 1) exp_rx = acc_pat;
        if (idle_now && start) begin
          acc     = ending;
          acc_tx  = tx_data;
          acc_pat = slave_pat;
        end
      end
    end
  end

  // compare every cycle against the model
  initial begin
    int   t;
    logic e_cs_n, e_sck, e_mosi, e_busy, e_done;
    forever begin
      @(negedge CLK);
      if (cyc >= 1) begin
        t = (acc >= 0) ? cyc - acc : -1;
        exp_at(t, acc_tx, e_cs_n, e_sck, e_mosi, e_busy, e_done);
        check("cs_n",    {31'd0, cs_n}, {31'd0, e_cs_n});
        check("sck",     {31'd0, sck},  {31'd0, e_sck});
        check("mosi",    {31'd0, mosi}, {31'd0, e_mosi});
        check("busy",    {31'd0, busy}, {31'd0, e_busy});
        check("done",    {31'd0, done}, {31'd0, e_done});
        check("rx_data", {16'd0, rx_data}, {16'd0, exp_rx});
      end
    end
  end

  // mode-0 slave: bit 15 on cs_n fall, next bit after each sck fall
  initial begin
    int   sl_idx;
    logic p_cs, p_sck;
    sl_idx = 15;
    p_cs   = 1'b1;
    p_sck  = 1'b0;
    miso   = 1'b0;
    forever begin
      @(negedge CLK);
      if (cs_n !== 1'b0) begin
        sl_idx = 15;
        miso   = 1'b0;
      end else if (p_cs === 1'b1) begin
        miso   = slave_pat[15];
        sl_idx = 14;
      end else if (p_sck === 1'b1 && sck === 1'b0 && sl_idx >= 0) begin
        miso   = slave_pat[sl_idx];
        sl_idx = sl_idx - 1;
      end
      p_cs  = cs_n;
      p_sck = sck;
    end
  end

  // event logger
  initial begin
    logic m_sck, m_cs;
    m_sck = 1'b0;
    m_cs  = 1'b1;
    forever begin
      @(negedge CLK);
      if (sck === 1'b1 && m_sck === 1'b0) sck_rises.push_back(cyc);
      if (cs_n === 1'b0 && m_cs === 1'b1) cs_fall.push_back(cyc);
      if (cs_n === 1'b1 && m_cs === 1'b0) cs_rise.push_back(cyc);
      if (done === 1'b1) done_q.push_back(cyc);
      if (mosi === 1'b1) mosi_hi++;
      m_sck = sck;
      m_cs  = cs_n;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic clear_logs();
    sck_rises.delete();
    cs_fall.delete();
    cs_rise.delete();
    done_q.delete();
    mosi_hi = 0;
  endtask

  initial begin
    int   s, s2;
    logic p_cs_n, p_sck, p_mosi, p_busy, p_done;

    // pin the timing model with hand-derived points for CLK_DIV=12
    exp_at(13, 16'h8001, p_cs_n, p_sck, p_mosi, p_busy, p_done);
    check("model_first_rise", {31'd0, p_sck}, 32'd1);
    exp_at(12, 16'h8001, p_cs_n, p_sck, p_mosi, p_busy, p_done);
    check("model_before_rise", {31'd0, p_sck}, 32'd0);
    exp_at(396, 16'h8001, p_cs_n, p_sck, p_mosi, p_busy, p_done);
    check("model_cs_last_low", {31'd0, p_cs_n}, 32'd0);
    exp_at(397, 16'h8001, p_cs_n, p_sck, p_mosi, p_busy, p_done);
    check("model_cs_rise", {31'd0, p_cs_n}, 32'd1);
    exp_at(409, 16'h8001, p_cs_n, p_sck, p_mosi, p_busy, p_done);
    check("model_done", {31'd0, p_done}, 32'd1);

    RST     = 1'b1;
    start   = 1'b0;
    tx_data = 16'h0;
    repeat (3) step();
    check("reset_cs_n", {31'd0, cs_n}, 32'd1);
    check("reset_rx",   {16'd0, rx_data}, 32'd0);
    RST = 1'b0;
    step();

    // frame 0x8001 with slave returning 0x3C96
    clear_logs();
    slave_pat = 16'h3C96;
    tx_data   = 16'h8001;
    start     = 1'b1;
    s         = cyc;
    step();
    start   = 1'b0;
    tx_data = 16'h0000;
    repeat (407) step();
    check("rx_before_done", {16'd0, rx_data}, 32'd0);
    step();
    check("rx_at_done", {16'd0, rx_data}, 32'h3C96);
    repeat (5) step();
    check("sck_rise_count", sck_rises.size(), 32'd16);
    for (int i = 0; i < sck_rises.size() && i < 16; i++)
      check("sck_rise_cycle", sck_rises[i] - s, 13 + 24 * i);
    check("cs_fall_count", cs_fall.size(), 32'd1);
    if (cs_fall.size() > 0) check("cs_fall_cycle", cs_fall[0] - s, 32'd1);
    check("cs_rise_count", cs_rise.size(), 32'd1);
    if (cs_rise.size() > 0) check("cs_rise_cycle", cs_rise[0] - s, 32'd397);
    check("done_count", done_q.size(), 32'd1);
    if (done_q.size() > 0) check("done_cycle", done_q[0] - s, 32'd409);
    check("mosi_high_cycles", mosi_hi, 32'd48);

    // request during a frame is ignored
    clear_logs();
    slave_pat = 16'h2468;
    tx_data   = 16'h1357;
    start     = 1'b1;
    s         = cyc;
    step();
    start = 1'b0;
    repeat (99) step();
    start   = 1'b1;
    tx_data = 16'hFFFF;
    step();
    start = 1'b0;
    repeat (340) step();
    check("ignored_done_count", done_q.size(), 32'd1);
    if (done_q.size() > 0) check("ignored_done_cycle", done_q[0] - s, 32'd409);
    check("ignored_sck_count", sck_rises.size(), 32'd16);
    check("ignored_rx", {16'd0, rx_data}, 32'h2468);

    // back-to-back frames with start held high
    clear_logs();
    slave_pat = 16'hA5C3;
    tx_data   = 16'h1234;
    start     = 1'b1;
    s         = cyc;
    step();
    tx_data = 16'hFFFF;
    repeat (409) step();
    start = 1'b0;
    repeat (420) step();
    check("b2b_done_count", done_q.size(), 32'd2);
    if (done_q.size() > 1) begin
      check("b2b_done0", done_q[0] - s, 32'd409);
      check("b2b_done1", done_q[1] - s, 32'd818);
    end
    if (cs_fall.size() > 1 && cs_rise.size() > 0)
      check("b2b_cs_high", cs_fall[1] - cs_rise[0], 32'd13);
    else
      check("b2b_cs_edges", cs_fall.size(), 32'd2);
    check("b2b_sck_count", sck_rises.size(), 32'd32);
    check("b2b_rx", {16'd0, rx_data}, 32'hA5C3);

    // reset mid-frame, then a clean frame
    clear_logs();
    slave_pat = 16'h0F0F;
    tx_data   = 16'h5AA5;
    start     = 1'b1;
    s         = cyc;
    step();
    start = 1'b0;
    repeat (199) step();
    RST   = 1'b1;
    start = 1'b1;
    step();
    RST   = 1'b0;
    start = 1'b0;
    check("rst_cs_n", {31'd0, cs_n}, 32'd1);
    check("rst_sck",  {31'd0, sck},  32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rx",   {16'd0, rx_data}, 32'd0);
    check("rst_no_done", done_q.size(), 32'd0);
    repeat (4) step();
    tx_data = 16'hC3A5;
    start   = 1'b1;
    s2      = cyc;
    step();
    start = 1'b0;
    repeat (420) step();
    check("after_rst_done_count", done_q.size(), 32'd1);
    if (done_q.size() > 0) check("after_rst_done_cycle", done_q[0] - s2, 32'd409);
    check("after_rst_rx", {16'd0, rx_data}, 32'h0F0F);

    // reset dominates a simultaneous start while idle
    RST   = 1'b1;
    start = 1'b1;
    step();
    RST   = 1'b0;
    start = 1'b0;
    repeat (3) step();
    check("rst_start_busy", {31'd0, busy}, 32'd0);
    check("rst_start_cs_n", {31'd0, cs_n}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master16.md
# spi_master16

The 16-bit SPI master (initiator) that drives the servo-angle link into `spi_slave`. It serialises one frame per `start` request, MSB first, in SPI mode 0 (CPOL=0, CPHA=0), with `cs_n` framing. It also captures 16 bits from `miso` during the same frame. It is used on-chip for loopback/self-test of the servo PWM path, and on a second pico2-ice board as the host-side angle sender; byte [15:8] is angle_x and byte [7:0] is angle_y.

## Interface
- `CLK_DIV`, default 12: SCK half-period in CLK cycles; legal range 4..255. At 48 MHz the default gives 2 MHz SCK.
- `CLK  in  1`: 48 MHz system clock; all logic on its rising edge.
- `RST  in  1`: reset, synchronous, active-high.
- `start  in  1`: single-cycle request; accepted only while `busy`=0.
- `tx_data  in  16`: frame to send; sampled in the cycle `start` is accepted.
- `busy  out  1`: high from the cycle after acceptance until `done`.
- `done  out  1`: one-cycle pulse at frame completion.
- `rx_data  out  16`: last frame captured from `miso`; updated in the `done` cycle and held otherwise.
- `sck  out  1`: SPI clock, idles low.
- `mosi  out  1`: serial data out, MSB first.
- `cs_n  out  1`: chip select, active low.
- `miso  in  1`: serial data in, asynchronous; passes through a 2-flop synchronizer.

## Operation
- States: IDLE, SETUP, SHIFT, GAP.
- **IDLE:**
  - Outputs: `cs_n`=1, `sck`=0, `mosi`=0, `busy`=0.
  - On `start`=1: load tx shift register with `tx_data`, clear the bit counter, go to SETUP.
- **SETUP** (CLK_DIV cycles):
  - `cs_n`=0, `mosi`=tx[15], `sck`=0.
  - Ends with the transition to SHIFT and `sck` rising.
- **SHIFT** (16 bits, 2×CLK_DIV cycles each):
  - High half: `sck`=1. In its first cycle, shift the synchronized `miso` into the rx shift register (LSB in).
  - Low half: `sck`=0. In its first cycle, `mosi` advances to the next bit.
  - After bit 15's low half, go to GAP. During that final low half `mosi` holds 0; it serves as CS hold time.
- **GAP** (CLK_DIV cycles):
  - `cs_n`=1, `sck`=0, `mosi`=0.
  - In its last cycle, transition to IDLE.
- **Completion:** the first cycle back in IDLE has `done`=1, `busy`=0, and `rx_data` = the rx shift register.
  - A `start` in that same cycle is accepted.
- **Busy handling:** `start` while `busy`=1 is ignored, not queued. `tx_data` changes while busy have no effect.
- **Reset:** `RST`=1 at any time (including mid-frame) sets state IDLE on the next edge.
  - `cs_n`=1, `sck`=0, `mosi`=0, `busy`=0, `done`=0, `rx_data`=0, all counters 0.
  - A partial frame is abandoned. The slave sees `cs_n` rise and discards it.
  - `RST` dominates a simultaneous `start`.
- **Counters:**
  - Half-period counter: $clog2(CLK_DIV) bits, wraps at CLK_DIV-1.
  - Bit counter: 4 bits, frame ends when it is 15 at the end of a low half.
  - No arithmetic wider than 16 bits.

## Timing
- All outputs are registered, with no combinational path from inputs to `sck`/`mosi`/`cs_n`.
- `start` is accepted at edge 0. Relative to that:
  - `cs_n` falls and `mosi`=bit15 at cycle 1.
  - First `sck` rise at cycle 1+CLK_DIV.
  - Bit i rises at cycle 1+CLK_DIV·(1+2i).
- `cs_n` is low for exactly 33·CLK_DIV cycles and rises at cycle 1+33·CLK_DIV.
- `done` fires at cycle 1+34·CLK_DIV. With CLK_DIV=12: first rise at 13, `cs_n` rises at 397, `done` at 409.
- Back-to-back frames give a minimum `cs_n`-high time of CLK_DIV+1 cycles.
- `mosi` is stable for ≥ CLK_DIV cycles either side of each `sck` rise.
- The `miso` sample is taken CLK_DIV cycles after the preceding fall. The slave must present data within CLK_DIV-3 cycles of a fall; 2 cycles are lost to the synchronizer. CLK_DIV ≥ 4 guarantees this for `spi_slave`.

## Structure
- Package `spi_pkg`:
  - `spi_state_t` enum (IDLE, SETUP, SHIFT, GAP).
  - `SPI_FRAME_BITS` = 16.
  - `SPI_DEFAULT_CLK_DIV` = 12.
- One sub-module, `sync2`: 2-flop synchronizer for `miso`, reset to 0.
- FSM, half-period counter, bit counter and both shift registers are inline in `spi_master16`.

## Test plan
- **Loopback:** `spi_master16` drives `spi_slave`; start with `tx_data`=0xB45A → slave `rx_valid` once, `data_out`=0xB45A; servo outputs reach angle_x=180, angle_y=90.
- **Cycle check, CLK_DIV=12, `tx_data`=0x8001:**
  - `cs_n` low cycles 1–396.
  - 16 `sck` rises, at 13, 37, …, 373.
  - `mosi` high only around the first and last rises.
  - `done` only at 409.
- **Receive:** bench models `miso` driving 0x3C96 per mode 0 → `rx_data`=0x3C96 at `done`, 0 before.
- **Back-to-back:** `start` held high with 0x1234 then 0xFFFF → two frames; `cs_n` high exactly 13 cycles between them; second `rx_data` updates at cycle 818.
- **Ignored request:** `start` pulsed at cycle 100 mid-frame → no effect; exactly one frame and one `done`.
- **Reset mid-frame:** `RST` at cycle 200 → next cycle `cs_n`=1, `sck`=0, `busy`=0, `rx_data`=0, no `done`; `start` at 205 → clean full frame, correct data.
